// File: rtl/func_sweep_checker_if.sv
// func_sweep_checker_if: sweep configuration, stimulus/response words and verdict readout.
interface func_sweep_checker_if #(
    parameter int WIDTH = 18,
    parameter int N_CH  = 1,
    parameter int CNT_W = 16,
    parameter int SUM_W = 2*WIDTH+CNT_W+4
);
    logic                    start;
    logic signed [WIDTH-1:0] start_val;
    logic signed [WIDTH-1:0] stop_val;
    logic [WIDTH-1:0]        step_val;
    logic [2*WIDTH-1:0]      tol_sq;
    logic signed [WIDTH-1:0] stim;
    logic [N_CH*WIDTH-1:0]   dut_out;
    logic [N_CH*WIDTH-1:0]   expct;
    logic                    busy;
    logic                    done;
    logic                    pass;
    logic [CNT_W-1:0]        n_samp;
    logic [SUM_W-1:0]        sum_err_sq;
    logic [WIDTH:0]          max_abs_err;
    modport master (
        output start, start_val, stop_val, step_val, tol_sq, dut_out, expct,
        input  stim, busy, done, pass, n_samp, sum_err_sq, max_abs_err
    );
    modport slave (
        input  start, start_val, stop_val, step_val, tol_sq, dut_out, expct,
        output stim, busy, done, pass, n_samp, sum_err_sq, max_abs_err
    );
endinterface

// File: rtl/func_sweep_checker.sv
// func_sweep_checker: sweeps a fixed-point stimulus, accumulates squared/peak error per channel
// and issues a square-root-free RMS verdict (sum <= tol_sq * points * channels).
module func_sweep_checker #(
    parameter int WIDTH         = 18,
    parameter int N_CH          = 1,
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_W         = 16,
    parameter int SUM_W         = 2*WIDTH+CNT_W+4
) (
    input logic                 emu_clk,
    input logic                 emu_rst_n,
    func_sweep_checker_if.slave bus
);
    localparam int SC_W  = $clog2(SETTLE_CYCLES+1);
    localparam int CH_W  = N_CH > 1 ? $clog2(N_CH) : 1;
    localparam int ACC_W = (SUM_W > 2*WIDTH ? SUM_W : 2*WIDTH) + 1;
    localparam int LIM_W = 2*WIDTH + CNT_W + $clog2(N_CH+1);
    localparam int CMP_W = ACC_W > LIM_W ? ACC_W : LIM_W;

    typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, ACCUM, STEP, CHECK, DONE} state_t;

    state_t                  state_q;
    logic signed [WIDTH-1:0] stim_q, stop_q;
    logic [WIDTH-1:0]        step_q;
    logic [2*WIDTH-1:0]      tol_q;
    logic [SC_W-1:0]         cnt_q;
    logic [CH_W-1:0]         ch_q;
    logic [N_CH*WIDTH-1:0]   dsnap_q, esnap_q;
    logic                    busy_q, done_q, pass_q, sat_q;
    logic [CNT_W-1:0]        n_q;
    logic [SUM_W-1:0]        sum_q;
    logic [WIDTH:0]          max_q;

    logic signed [WIDTH-1:0] exp_d, dut_d;
    logic signed [WIDTH:0]   err_d;
    logic [WIDTH-1:0]        abs_d;
    logic [2*WIDTH-1:0]      sq_d;
    logic [ACC_W-1:0]        acc_d;
    logic                    sat_d;
    logic signed [WIDTH+1:0] nxt_d, stop_x_d;
    logic [CNT_W-1:0]        n_inc_d;
    logic [LIM_W-1:0]        lim_d;
    logic                    pass_d;

    always_comb begin
        exp_d    = esnap_q[ch_q*WIDTH +: WIDTH];
        dut_d    = dsnap_q[ch_q*WIDTH +: WIDTH];
        err_d    = {exp_d[WIDTH-1], exp_d} - {dut_d[WIDTH-1], dut_d};
        // |e| never exceeds 2^WIDTH-1, so WIDTH bits hold the magnitude
        abs_d    = err_d[WIDTH] ? WIDTH'(-err_d) : err_d[WIDTH-1:0];
        sq_d     = {{WIDTH{1'b0}}, abs_d} * {{WIDTH{1'b0}}, abs_d};
        acc_d    = ACC_W'(sum_q) + ACC_W'(sq_d);
        sat_d    = |acc_d[ACC_W-1:SUM_W];
        nxt_d    = {{2{stim_q[WIDTH-1]}}, stim_q} + {2'b00, step_q};
        stop_x_d = {{2{stop_q[WIDTH-1]}}, stop_q};
        n_inc_d  = n_q + CNT_W'(1);
        lim_d    = LIM_W'(tol_q) * LIM_W'(n_q) * LIM_W'(N_CH);
        pass_d   = (n_q != '0) && !sat_q && (CMP_W'(sum_q) <= CMP_W'(lim_d));
    end

    always_ff @(posedge emu_clk or negedge emu_rst_n) begin
        if (!emu_rst_n) begin
            state_q <= IDLE;
            stim_q  <= '0;
            stop_q  <= '0;
            step_q  <= '0;
            tol_q   <= '0;
            cnt_q   <= '0;
            ch_q    <= '0;
            dsnap_q <= '0;
            esnap_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            sat_q   <= 1'b0;
            n_q     <= '0;
            sum_q   <= '0;
            max_q   <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: if (bus.start) begin
                    stop_q  <= bus.stop_val;
                    step_q  <= bus.step_val == '0 ? WIDTH'(1) : bus.step_val;
                    tol_q   <= bus.tol_sq;
                    cnt_q   <= '0;
                    n_q     <= '0;
                    sum_q   <= '0;
                    max_q   <= '0;
                    sat_q   <= 1'b0;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                    busy_q  <= 1'b1;
                    if (bus.start_val > bus.stop_val) state_q <= CHECK;
                    else begin
                        stim_q  <= bus.start_val;
                        state_q <= SETTLE;
                    end
                end
                SETTLE: if (cnt_q == SC_W'(SETTLE_CYCLES-1)) begin
                    esnap_q <= bus.expct;
                    dsnap_q <= bus.dut_out;
                    ch_q    <= '0;
                    state_q <= SAMPLE;
                end else cnt_q <= cnt_q + 1'b1;
                SAMPLE: state_q <= ACCUM;
                ACCUM: begin
                    sum_q <= sat_d ? '1 : acc_d[SUM_W-1:0];
                    sat_q <= sat_q | sat_d;
                    max_q <= {1'b0, abs_d} > max_q ? {1'b0, abs_d} : max_q;
                    if (ch_q == CH_W'(N_CH-1)) state_q <= STEP;
                    else ch_q <= ch_q + 1'b1;
                end
                STEP: begin
                    n_q   <= n_inc_d;
                    cnt_q <= '0;
                    // the overshooting value is never driven, so stim cannot wrap
                    if (nxt_d > stop_x_d || n_inc_d == '1) state_q <= CHECK;
                    else begin
                        stim_q  <= nxt_d[WIDTH-1:0];
                        state_q <= SETTLE;
                    end
                end
                CHECK: begin
                    pass_q  <= pass_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.stim        = stim_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.pass        = pass_q;
    assign bus.n_samp      = n_q;
    assign bus.sum_err_sq  = sum_q;
    assign bus.max_abs_err = max_q;
endmodule

// File: tb/tb_func_sweep_checker.sv
// tb_func_sweep_checker: sweeps scored against a list-based reference model via queues;
// a small-accumulator instance covers saturation.
module tb_func_sweep_checker;
    localparam int W = 18, NC = 2, SC = 4, CW = 16;
    localparam logic [W-1:0] MAXP = 18'h1FFFF, MINN = 18'h20000;

    typedef struct {
        longint n, sum, mx, pass, done_cyc;
    } res_t;

    logic   emu_clk = 1'b0;
    logic   emu_rst_n = 1'b1;
    int     cyc = 0, total = 0, bad = 0;
    int     off0 = 0, off1 = 0;
    res_t   res_q[$];
    longint stim_q[$];
    longint last_stim = 0;

    always #5 emu_clk = ~emu_clk;
    always @(posedge emu_clk) cyc <= cyc + 1;

    func_sweep_checker_if #(.WIDTH(W), .N_CH(NC), .CNT_W(CW)) bus();
    func_sweep_checker_if #(.WIDTH(W), .N_CH(NC), .CNT_W(CW), .SUM_W(8)) sbus();

    func_sweep_checker #(.WIDTH(W), .N_CH(NC), .SETTLE_CYCLES(SC), .CNT_W(CW)) dut (
        .emu_clk(emu_clk), .emu_rst_n(emu_rst_n), .bus(bus));
    func_sweep_checker #(.WIDTH(W), .N_CH(NC), .SETTLE_CYCLES(SC), .CNT_W(CW), .SUM_W(8)) u_sat (
        .emu_clk(emu_clk), .emu_rst_n(emu_rst_n), .bus(sbus));

    // emulated function block: golden = stim, channel k = stim + offset k
    assign bus.expct    = {bus.stim, bus.stim};
    assign bus.dut_out  = {W'(bus.stim + off1), W'(bus.stim + off0)};
    assign sbus.expct   = {MAXP, MAXP};
    assign sbus.dut_out = {MINN, MINN};

    task automatic chk(string nm, logic signed [63:0] act, longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic longint wrap(longint v);
        logic signed [W-1:0] t;
        t = v[W-1:0];
        return t;
    endfunction

    task automatic chk_zero(string tag);
        chk({tag, "_stim"}, $signed(bus.stim), 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_pass"}, bus.pass, 0);
        chk({tag, "_n"}, bus.n_samp, 0);
        chk({tag, "_sum"}, bus.sum_err_sq, 0);
        chk({tag, "_max"}, bus.max_abs_err, 0);
    endtask

    task automatic pulse_start(longint s, longint e, longint st, longint tol);
        bus.start_val = W'(s);
        bus.stop_val  = W'(e);
        bus.step_val  = W'(st);
        bus.tol_sq    = (2*W)'(tol);
        bus.start     = 1'b1;
        @(negedge emu_clk);
        bus.start     = 1'b0;
    endtask

    task automatic run(longint s, longint e, longint st, longint tol, int o0, int o1, bit poke);
        longint step = st == 0 ? 1 : st;
        int     offs[2] = '{o0, o1};
        res_t   r = '{0, 0, 0, 0, 0};
        @(negedge emu_clk);
        off0 = o0;
        off1 = o1;
        for (longint v = s; v <= e; v += step) begin
            stim_q.push_back(v);
            r.n++;
            foreach (offs[k]) begin
                longint d = v - wrap(v + offs[k]);
                r.sum += d * d;
                if ((d < 0 ? -d : d) > r.mx) r.mx = d < 0 ? -d : d;
            end
            last_stim = v;
        end
        if (r.n == 0) stim_q.push_back(last_stim);
        r.pass = (r.n > 0 && r.sum <= tol * r.n * NC) ? 1 : 0;
        r.done_cyc = cyc + r.n * (SC + NC + 2) + 2;
        res_q.push_back(r);
        pulse_start(s, e, st, tol);
        if (poke) begin
            repeat (9) @(negedge emu_clk);
            pulse_start(100, -100, 1, 1000);
        end
        for (longint i = 0; i < r.n * 8 + 40 && !bus.done; i++) @(negedge emu_clk);
        chk("done_in_time", bus.done, 1);
        @(negedge emu_clk);
    endtask

    res_t        mr;
    logic        busy_p = 1'b0, done_p = 1'b0;
    logic [W-1:0] stim_p = '0;

    always @(negedge emu_clk) begin
        if (emu_rst_n) begin
            if (bus.busy && (!busy_p || bus.stim != stim_p)) begin
                if (stim_q.size() == 0) chk("stim_unexpected", $signed(bus.stim), -999999);
                else chk("stim", $signed(bus.stim), stim_q.pop_front());
            end
            if (bus.done && !done_p) begin
                if (res_q.size() == 0) chk("done_unexpected", bus.done, 0);
                else begin
                    mr = res_q.pop_front();
                    chk("n_samp", bus.n_samp, mr.n);
                    chk("sum_err_sq", bus.sum_err_sq, mr.sum);
                    chk("max_abs_err", bus.max_abs_err, mr.mx);
                    chk("pass", bus.pass, mr.pass);
                    chk("done_cycle", cyc, mr.done_cyc);
                end
            end
        end
        busy_p <= bus.busy;
        done_p <= bus.done;
        stim_p <= bus.stim;
    end

    initial begin
        bus.start = 1'b0; bus.start_val = '0; bus.stop_val = '0; bus.step_val = '0; bus.tol_sq = '0;
        sbus.start = 1'b0; sbus.start_val = '0; sbus.stop_val = '0; sbus.step_val = 18'd1; sbus.tol_sq = '1;
        #2 emu_rst_n = 1'b0;
        #1 chk_zero("reset");
        repeat (2) @(negedge emu_clk);
        emu_rst_n = 1'b1;

        run(-10, 10, 5, 0, 0, 0, 1);
        run(-10, 10, 5, 4, 0, 3, 0);
        run(-10, 10, 5, 5, 0, 3, 0);
        run(10, -10, 1, 100, 0, 0, 0);
        run(0, 10, 4, 0, 0, 0, 0);
        run(131069, 131071, 4, 0, 0, 0, 0);
        run(-3, 3, 0, 1, -1, 1, 0);

        // reset during the second point's settle interval
        @(negedge emu_clk);
        off0 = 0; off1 = 0;
        stim_q.push_back(-10);
        stim_q.push_back(-5);
        pulse_start(-10, 10, 5, 0);
        repeat (9) @(negedge emu_clk);
        chk("mid_n_samp", bus.n_samp, 1);
        #2 emu_rst_n = 1'b0;
        #1 chk_zero("midreset");
        chk("points_before_reset", stim_q.size(), 0);
        stim_q.delete();
        last_stim = 0;
        @(negedge emu_clk);
        emu_rst_n = 1'b1;

        for (int i = 0; i < 20; i++)
            run(int'($urandom_range(600)) - 300, 0, 0, 0, 0, 0, 0) ;

        for (int i = 0; i < 20; i++) begin
            longint s = longint'($urandom_range(600)) - 300;
            run(s, s + longint'($urandom_range(220)) - 20, $urandom_range(60), $urandom_range(80),
                int'($urandom_range(16)) - 8, int'($urandom_range(16)) - 8, 0);
        end

        @(negedge emu_clk);
        sbus.start = 1'b1;
        @(negedge emu_clk);
        sbus.start = 1'b0;
        for (int i = 0; i < 50 && !sbus.done; i++) @(negedge emu_clk);
        chk("sat_done", sbus.done, 1);
        chk("sat_n", sbus.n_samp, 1);
        chk("sat_sum", sbus.sum_err_sq, 255);
        chk("sat_max", sbus.max_abs_err, 262143);
        chk("sat_pass", sbus.pass, 0);

        repeat (2) @(negedge emu_clk);
        chk("queues_drained", res_q.size() + stim_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/func_sweep_checker.md
# func_sweep_checker

Synthesizable, emulator-resident sweep-and-check controller for function-approximation blocks. Steps a fixed-point stimulus from a start value to a stop value by a programmable step and holds each point for a settling interval. It then compares N_CH DUT outputs against externally supplied golden values and accumulates squared error and peak error. At sweep end it issues an RMS pass/fail verdict, using a square-root-free comparison, for readout over the emulator control interface.

## Interface
- WIDTH, 18: bit width of stim, dut_out and expct words (signed two's complement, common exponent)
- N_CH, 1: number of DUT output channels checked per point
- SETTLE_CYCLES, 16: cycles stim is held stable before sampling (>=1)
- CNT_W, 16: width of sample counter
- SUM_W, 2*WIDTH+CNT_W+4: width of squared-error accumulator
- emu_clk  in  1  emulator clock; all logic rising-edge
- emu_rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; launches a sweep from IDLE or DONE
- start_val  in  WIDTH  first stimulus value (signed)
- stop_val  in  WIDTH  last permissible stimulus value (signed, inclusive)
- step_val  in  WIDTH  increment (unsigned, must be >0; 0 treated as 1)
- tol_sq  in  2*WIDTH  squared RMS tolerance in LSB² (unsigned)
- stim  out  WIDTH  stimulus to DUT and golden model
- dut_out  in  N_CH*WIDTH  packed DUT outputs, channel 0 in LSBs
- expct  in  N_CH*WIDTH  packed golden values for current stim
- busy  out  1  high from accepted start until DONE
- done  out  1  high in DONE
- pass  out  1  verdict, valid while done
- n_samp  out  CNT_W  number of sweep points sampled
- sum_err_sq  out  SUM_W  Σ over points and channels of (expct−dut_out)²
- max_abs_err  out  WIDTH+1  peak |expct−dut_out| seen

## Operation
- Reset (async assert): state IDLE; stim, busy, done, pass, n_samp, sum_err_sq, max_abs_err all 0. Reset deassertion is synchronous to emu_clk.
- Config inputs are latched on accepted start; later changes do not affect the running sweep.
- States: IDLE, SETTLE, SAMPLE, ACCUM, STEP, CHECK, DONE.
- IDLE/DONE + start: clear n_samp, sum, max, done, pass. If start_val>stop_val, go to CHECK with no samples. Otherwise set stim=start_val and go to SETTLE.
- start while busy is ignored.
- SETTLE: count SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE: one cycle; register all dut_out and expct words into snapshot regs.
- ACCUM: N_CH cycles, channel k on cycle k, through one shared multiplier.
  - e = expct_k − dut_out_k, computed in WIDTH+1 bits with no overflow.
  - sum += e² (saturating; a saturation sets a sticky sat flag).
  - max_abs_err = max(max_abs_err, |e|).
- STEP: n_samp += 1.
  - next = stim + step, computed in WIDTH+2 bits.
  - If next > stop_val, or n_samp has reached 2^CNT_W−1, go to CHECK.
  - Otherwise set stim=next and go to SETTLE. stim never wraps.
- CHECK: one cycle; pass = (n_samp>0) & !sat & (sum_err_sq <= tol_sq·n_samp·N_CH). The product is full-width, with no truncation.
- DONE: done=1, busy=0. stim holds its last value. Results hold until next start or reset.
- Reset mid-sweep: immediate return to IDLE, all outputs 0; no partial verdict.

## Timing
- Accepted start → busy=1 next cycle; stim=start_val the same cycle.
- Per point: SETTLE_CYCLES + 1 + N_CH + 1 cycles; stim is constant for the whole interval.
- Snapshot taken exactly SETTLE_CYCLES cycles after stim changes.
- Last STEP → CHECK (1 cycle) → done=1 and pass valid on the following cycle.
- Total from start to done: P·(SETTLE_CYCLES+N_CH+2)+2 cycles, for P points. With P=0 (start_val>stop_val): 2 cycles.
- n_samp, sum_err_sq and max_abs_err update in registers and are observable mid-sweep.

## Test plan
- Ideal DUT (WIDTH=18, N_CH=2, SETTLE_CYCLES=4; dut_out=expct=stim), start=−10, stop=10, step=5 → stim −10,−5,0,5,10; n_samp=5; sum=0; max=0; pass=1; done 42 cycles after start.
- Ch1 offset +3 LSB, same sweep → sum=45, max=3. With tol_sq=4: pass=0 (45>40). With tol_sq=5: pass=1 (45≤50).
- start=10, stop=−10 → n_samp=0, done after 2 cycles, pass=0.
- start=0, stop=10, step=4 → stim 0,4,8 only, n_samp=3. Then start=131069, stop=131071, step=4 → one point, stim stays 131069 with no wrap.
- Assert emu_rst_n low during the second point's SETTLE → all outputs 0 immediately, state IDLE. A start pulse issued while busy produces no restart (sample count unaffected).
- SUM_W forced small with max-magnitude errors → sum saturates at all-ones, pass=0 regardless of tol_sq.
